// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between instruction fetch
// and the load/store unit. One access per cycle, with combinational grants
// and the response registered one cycle after the grant. Data accesses win,
// except when fetch has been denied for STARVE_LIMIT cycles in a row.
module imem_dmem_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port (read only)
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  // load/store port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  // memory side
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  localparam int            CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              if_rv_q, if_rv_d;
  logic              d_rv_q, d_rv_d;
  logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic              if_gnt, d_gnt;

  // Grant selection: flush blocks fetch, starvation override, then data, then fetch.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    // requests are ignored while reset is held
    if (rst) begin
      if (if_flush_i) begin
        d_gnt = d_req_i;
      end else if ((wait_cnt_q >= CNT_LIMIT) && if_req_i) begin
        if_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end else if (if_req_i) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req_i || if_flush_i || if_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  // Memory drive: route the granted requester; everything is zero when idle.
  always_comb begin
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (if_gnt) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
    end else if (d_gnt) begin
      mem_addr_o = d_addr_i;
      if (d_we_i) begin
        mem_write_en_o = 1'b1;
        mem_wdata_o    = d_wdata_i;
      end else begin
        mem_read_en_o = 1'b1;
      end
    end
  end

  // Response capture: valid for one cycle after each grant; data holds otherwise.
  always_comb begin
    if_rv_d    = if_gnt;
    d_rv_d     = d_gnt;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_gnt) begin
      if_rdata_d = mem_rdata_i;
    end
    // stores answer with zero data
    if (d_gnt) begin
      d_rdata_d = d_we_i ? '0 : mem_rdata_i;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      if_rv_q    <= 1'b0;
      d_rv_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if_rv_q    <= if_rv_d;
      d_rv_q     <= d_rv_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  // a flush in the response cycle squashes the fetch response
  assign if_rvalid_o = if_rv_q && !if_flush_i;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rv_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed vectors drive the requesters and
// push expected responses into per-port queues; a negedge monitor pops and
// compares whenever the arbiter presents a response.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_en_o, mem_write_en_o;

  logic [31:0] mem_arr [256];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  imem_dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, write commits at the clock edge.
  // Preloaded with 0xA500_0000 + word index while reset is held.
  assign mem_rdata_i = mem_arr[mem_addr_o[9:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA500_0000 + i;
    end else if (mem_write_en_o) begin
      mem_arr[mem_addr_o[9:2]] <= mem_wdata_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented response must match the head of its queue.
  always @(negedge clk) begin
    if (if_rvalid_o === 1'b1) begin
      if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        automatic logic [31:0] e = if_q.pop_front();
        $display("t=%0t fetch resp data=%h exp=%h", $time, if_rdata_o, e);
        chk("if_rdata", if_rdata_o, e);
      end
    end
    if (d_rvalid_o === 1'b1) begin
      if (d_q.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        automatic logic [31:0] e = d_q.pop_front();
        $display("t=%0t data resp data=%h exp=%h", $time, d_rdata_o, e);
        chk("d_rdata", d_rdata_o, e);
      end
    end
  end

  // One cycle: drive inputs, check grants and memory drive at negedge,
  // optionally queue the expected response, then move past the next posedge.
  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic flush,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic exp_ig, input logic exp_dg,
                      input logic [31:0] exp_data, input logic push);
    if_req_i = ireq; if_addr_i = iaddr; if_flush_i = flush;
    d_req_i = dreq; d_we_i = dwe; d_addr_i = daddr; d_wdata_i = dwdata;
    @(negedge clk);
    chk("if_gnt", {31'd0, if_gnt_o}, {31'd0, exp_ig});
    chk("d_gnt", {31'd0, d_gnt_o}, {31'd0, exp_dg});
    if (exp_ig) begin
      chk("mem_addr_if", mem_addr_o, iaddr);
      chk("mem_ren_if", {31'd0, mem_read_en_o}, 32'd1);
    end else if (exp_dg) begin
      chk("mem_addr_d", mem_addr_o, daddr);
      chk("mem_wen_d", {31'd0, mem_write_en_o}, {31'd0, dwe});
      if (dwe) chk("mem_wdata", mem_wdata_o, dwdata);
    end else begin
      chk("mem_idle_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    end
    if (push && exp_ig) if_q.push_back(exp_data);
    if (push && exp_dg) d_q.push_back(exp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    @(posedge clk); #1;

    // Reset held with both requests pending: nothing granted or returned.
    step(1, 32'h0100_0000, 0, 1, 0, 32'h0100_0010, 0, 0, 0, 0, 0);
    step(1, 32'h0100_0000, 0, 1, 0, 32'h0100_0010, 0, 0, 0, 0, 0);
    chk("rst_if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    rst = 1'b1;
    // First cycle after release grants data.
    step(1, 32'h0100_0000, 0, 1, 0, 32'h0100_0010, 0, 0, 1, 32'hA500_0004, 1);
    idle();

    // Fetch-only stream.
    step(1, 32'h0100_0000, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0000, 1);
    step(1, 32'h0100_0004, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0001, 1);
    step(1, 32'h0100_0008, 0, 0, 0, 0, 0, 1, 0, 32'hA500_0002, 1);
    idle();

    // Starvation: data x4, fetch, data.
    for (int i = 0; i < 4; i++)
      step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 0, 1, 32'hA500_0008, 1);
    step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 1, 0, 32'hA500_0003, 1);
    step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 0, 1, 32'hA500_0008, 1);
    idle();

    // Store then load the same word back-to-back.
    step(0, 0, 0, 1, 1, 32'h0100_0100, 32'hDEAD_BEEF, 0, 1, 32'h0, 1);
    step(0, 0, 0, 1, 0, 32'h0100_0100, 0, 0, 1, 32'hDEAD_BEEF, 1);
    idle();

    // Flush kills a fetch response in the same cycle and blocks fetch.
    step(1, 32'h0100_0004, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    if_req_i = 1; if_flush_i = 1; d_req_i = 0;
    @(negedge clk);
    chk("flush_if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    chk("flush_if_gnt", {31'd0, if_gnt_o}, 32'd0);
    @(posedge clk); #1;
    idle();

    // Flush clears a partly built starvation count: data wins 4 more times.
    for (int i = 0; i < 3; i++)
      step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 0, 1, 32'hA500_0008, 1);
    step(1, 32'h0100_000C, 1, 1, 0, 32'h0100_0020, 0, 0, 1, 32'hA500_0008, 1);
    for (int i = 0; i < 4; i++)
      step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 0, 1, 32'hA500_0008, 1);
    step(1, 32'h0100_000C, 0, 1, 0, 32'h0100_0020, 0, 1, 0, 32'hA500_0003, 1);
    idle();

    // Asynchronous reset between edges drops an in-flight load response.
    step(0, 0, 0, 1, 0, 32'h0100_0100, 0, 0, 1, 0, 0);
    d_req_i = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    chk("async_d_rdata", d_rdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    chk("post_rst_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    idle();
    chk("post_rst_d_rvalid2", {31'd0, d_rvalid_o}, 32'd0);

    chk("if_queue_empty", if_q.size(), 32'd0);
    chk("d_queue_empty", d_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
